// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch with response FIFO and branch redirect
// Optional IFU_STALL_COUNT_EN adds the o_stall_cycles downstream-starvation counter.
module instr_fetch_unit #(
   parameter logic [63:0] RESET_ADDR = 64'h0000_0000_0000_0100,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_32b_mode,
   input  logic        i_redirect_valid,
   input  logic [63:0] i_redirect_addr,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [63:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instr,
   output logic [63:0] o_instr_addr
`ifdef IFU_STALL_COUNT_EN
   ,
   output logic [31:0] o_stall_cycles
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]   pc;
   logic [63:0]   fill_addr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   data_mem [FIFO_DEPTH];
   logic [63:0]   addr_mem [FIFO_DEPTH];
   logic          live;

   logic [CW:0]   occupancy;
   logic          req_fire;
   logic          pop;
   logic          keep;
   logic          rsp_drop;
   logic [CW-1:0] outstanding_next;
   logic [63:0]   redirect_target;

   function automatic logic [63:0] mask_addr(input logic [63:0] a, input logic m32);
      mask_addr = m32 ? {32'h0, a[31:0]} : a;
   endfunction

   // Counting outstanding requests against free slots means a response never finds the FIFO full.
   always_comb begin
      occupancy        = {1'b0, count} + {1'b0, outstanding};
      o_imem_req_valid = live && i_en && (occupancy < (CW+1)'(FIFO_DEPTH));
      o_imem_req_addr  = mask_addr(pc, i_32b_mode);
      req_fire         = o_imem_req_valid && i_imem_req_ready;
      o_instr_valid    = (count != '0);
      pop              = o_instr_valid && i_instr_ready;
      rsp_drop         = (drop != '0);
      keep             = i_imem_rsp_valid && !rsp_drop && !i_redirect_valid;
      outstanding_next = outstanding + CW'(req_fire) - CW'(i_imem_rsp_valid);
      redirect_target  = mask_addr(i_redirect_addr & ~64'h3, i_32b_mode);
   end

   assign o_instr      = data_mem[rd_ptr];
   assign o_instr_addr = addr_mem[rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         live        <= 1'b0;
         pc          <= RESET_ADDR;
         fill_addr   <= RESET_ADDR;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_mem[i] <= '0;
            addr_mem[i] <= '0;
         end
      end else begin
         live        <= 1'b1;
         outstanding <= outstanding_next;
         if (i_redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            pc        <= redirect_target;
            fill_addr <= redirect_target;
            drop      <= outstanding_next;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
         end else begin
            if (req_fire)
               pc <= mask_addr(pc + 64'd4, i_32b_mode);
            if (i_imem_rsp_valid && rsp_drop)
               drop <= drop - CW'(1);
            if (keep) begin
               data_mem[wr_ptr] <= i_imem_rsp_data;
               addr_mem[wr_ptr] <= fill_addr;
               wr_ptr           <= wr_ptr + PW'(1);
               fill_addr        <= mask_addr(fill_addr + 64'd4, i_32b_mode);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            case ({keep, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

`ifdef IFU_STALL_COUNT_EN
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         o_stall_cycles <= '0;
      else if (i_instr_ready && !o_instr_valid && (o_stall_cycles != 32'hFFFF_FFFF))
         o_stall_cycles <= o_stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic        redir = 1'b0;
   logic [63:0] raddr = '0;
   logic        req_valid;
   logic        mready = 1'b1;
   logic [63:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        instr_valid;
   logic        iready = 1'b0;
   logic [31:0] instr;
   logic [63:0] instr_addr;
`ifdef IFU_STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   logic        n_en = 1'b0;
   logic        n_mode = 1'b0;
   logic        n_redir = 1'b0;
   logic [63:0] n_raddr = '0;
   logic        n_iready = 1'b0;

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int acc = 0;
   int lat = 1;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } exp_t;
   typedef struct {
      logic [63:0] addr;
      int          due;
   } pend_t;

   exp_t        sb[$];
   logic [63:0] req_sb[$];
   pend_t       pend[$];

   instr_fetch_unit dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .i_en             (en),
      .i_32b_mode       (mode),
      .i_redirect_valid (redir),
      .i_redirect_addr  (raddr),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (mready),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_instr_valid    (instr_valid),
      .i_instr_ready    (iready),
      .o_instr          (instr),
      .o_instr_addr     (instr_addr)
`ifdef IFU_STALL_COUNT_EN
      ,
      .o_stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (instr_valid && iready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_instr: got addr %h data %h expected none", instr_addr, instr);
               end else begin
                  e = sb.pop_front();
                  check64("instr_addr", instr_addr, e.addr);
                  check64("instr_data", {32'h0, instr}, {32'h0, e.data});
               end
            end
            if (req_valid && mready && req_sb.size() != 0)
               check64("req_addr", req_addr, req_sb.pop_front());
         end
      end
   end

   task automatic step();
      pend_t p;
      @(posedge clk);
      #1;
      en     = n_en;
      mode   = n_mode;
      redir  = n_redir;
      raddr  = n_raddr;
      iready = n_iready;
      cycle++;
      if (pend.size() != 0 && pend[0].due <= cycle) begin
         rsp_valid = 1'b1;
         rsp_data  = pend[0].addr[31:0];
         void'(pend.pop_front());
      end else begin
         rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_n && req_valid && mready) begin
         p.addr = req_addr;
         p.due  = cycle + lat;
         pend.push_back(p);
         acc++;
      end
   endtask

   task automatic clear_models();
      n_en = 0; n_mode = 0; n_redir = 0; n_iready = 0;
      en = 0; mode = 0; redir = 0; iready = 0; rsp_valid = 0;
      pend.delete();
      sb.delete();
      req_sb.delete();
      acc = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_models();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic fetch_n(input int n);
      int target;
      int guard;
      target = acc + n;
      guard  = 0;
      n_en   = 1'b1;
      while (acc < target && guard < 300) begin
         step();
         guard++;
      end
      n_en = 1'b0;
      total++;
      if (acc < target) begin
         bad++;
         $display("FAIL fetch_timeout: accepted %0d required %0d", acc, target);
      end
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         step();
         guard++;
      end
      repeat (8) step();
      total++;
      if (sb.size() != 0 || req_sb.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: left instr %0d req %0d expected 0 0", name, sb.size(), req_sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values, with fetch enabled so req_valid gating is exercised
      en     = 1'b1;
      iready = 1'b1;
      #23;
      check64("rst_req_valid", {63'h0, req_valid}, 64'h0);
      check64("rst_req_addr", req_addr, 64'h100);
      check64("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
      check64("rst_instr", {32'h0, instr}, 64'h0);
      check64("rst_instr_addr", instr_addr, 64'h0);

      // linear stream, latency 1
      do_reset();
      lat = 1;
      n_iready = 1'b1;
      for (int i = 0; i < 8; i++) push_exp(64'h100 + 64'(4 * i), 32'h100 + 32'(4 * i));
      fetch_n(8);
      drain("linear");

      // back-pressure fills exactly FIFO_DEPTH, then resumes at 0x110
      do_reset();
      lat = 1;
      n_iready = 1'b0;
      n_en = 1'b1;
      repeat (10) step();
      check64("bp_accepted", 64'(acc), 64'd4);
      check64("bp_req_valid", {63'h0, req_valid}, 64'h0);
      for (int i = 0; i < 8; i++) push_exp(64'h100 + 64'(4 * i), 32'h100 + 32'(4 * i));
      req_sb.push_back(64'h110);
      n_iready = 1'b1;
      fetch_n(4);
      drain("backpressure");

      // redirect with 3 requests outstanding at latency 5
      do_reset();
      lat = 5;
      n_iready = 1'b1;
      fetch_n(3);
      n_redir = 1'b1;
      n_raddr = 64'h2003;
      req_sb.push_back(64'h2000);
      step();
      n_redir = 1'b0;
      step();
      for (int i = 0; i < 4; i++) push_exp(64'h2000 + 64'(4 * i), 32'h2000 + 32'(4 * i));
      fetch_n(4);
      drain("redirect");

      // redirect in the same cycle as the pop of 0x104
      do_reset();
      lat = 1;
      n_iready = 1'b0;
      fetch_n(4);
      repeat (3) step();
      push_exp(64'h100, 32'h100);
      push_exp(64'h104, 32'h104);
      n_iready = 1'b1;
      step();
      n_redir = 1'b1;
      n_raddr = 64'h3000;
      step();
      n_redir = 1'b0;
      step();
      check64("pop_redirect_consumed", 64'(sb.size()), 64'd0);
      repeat (4) step();
      push_exp(64'h3000, 32'h3000);
      push_exp(64'h3004, 32'h3004);
      fetch_n(2);
      drain("pop_redirect");

      // 32-bit mode wrap at the top of the low 4 GiB
      do_reset();
      lat = 1;
      n_iready = 1'b1;
      n_mode = 1'b1;
      n_redir = 1'b1;
      n_raddr = 64'hFFFF_FFFF_FFFF_FFF8;
      req_sb.push_back(64'h0000_0000_FFFF_FFF8);
      req_sb.push_back(64'h0000_0000_FFFF_FFFC);
      req_sb.push_back(64'h0000_0000_0000_0000);
      step();
      n_redir = 1'b0;
      push_exp(64'h0000_0000_FFFF_FFF8, 32'hFFFF_FFF8);
      push_exp(64'h0000_0000_FFFF_FFFC, 32'hFFFF_FFFC);
      push_exp(64'h0000_0000_0000_0000, 32'h0000_0000);
      fetch_n(3);
      drain("mode32");

      // asynchronous reset mid-stream with 2 outstanding
      do_reset();
      lat = 5;
      n_iready = 1'b1;
      fetch_n(2);
      step();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check64("arst_req_valid", {63'h0, req_valid}, 64'h0);
      check64("arst_req_addr", req_addr, 64'h100);
      check64("arst_instr_valid", {63'h0, instr_valid}, 64'h0);
      check64("arst_instr", {32'h0, instr}, 64'h0);
      check64("arst_instr_addr", instr_addr, 64'h0);
      clear_models();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lat = 1;
      n_iready = 1'b1;
      req_sb.push_back(64'h100);
      for (int i = 0; i < 4; i++) push_exp(64'h100 + 64'(4 * i), 32'h100 + 32'(4 * i));
      fetch_n(4);
      drain("async_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
